fifo_wr_arb: RTL and testbench

- Single-clock controller that shares the write port of the dual-port FIFO RAM between two producers and sequences its read port for one consumer.
- Owns write/read pointers, fill level and the full/empty flags fed to the RAM.
- Round-robin arbitration with a bounded burst per grant.
- Sits between the two producers (pixel path and control path into SDRAM staging) and the RAM instance.

---
 rtl/fifo_wr_arb.sv | 174 +++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arb.sv
// Two-producer round-robin write arbiter and pointer/level controller for a dual-port FIFO RAM.
// Optional stall statistics outputs are enabled with FIFO_WR_ARB_STAT_EN.
module fifo_wr_arb #(
  parameter int FIFO_data_size = 16,
  parameter int FIFO_addr_size = 4,
  parameter int BURST_LEN      = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req0,
  input  logic [FIFO_data_size-1:0] data0,
  output logic                      ack0,
  input  logic                      req1,
  input  logic [FIFO_data_size-1:0] data1,
  output logic                      ack1,
  input  logic                      rd_req,
  output logic                      rd_ack,
  output logic                      rd_valid,
  output logic                      w_en,
  output logic [FIFO_addr_size-1:0] w_addr,
  output logic [FIFO_data_size-1:0] w_data,
  output logic                      r_en,
  output logic [FIFO_addr_size-1:0] r_addr,
  output logic                      full,
  output logic                      empty,
  output logic [FIFO_addr_size:0]   level,
  output logic [1:0]                grant
`ifdef FIFO_WR_ARB_STAT_EN
  ,
  output logic [15:0]               stall0_cnt,
  output logic [15:0]               stall1_cnt
`endif
);

  localparam int unsigned                 DEPTH      = 1 << FIFO_addr_size;
  localparam logic [FIFO_addr_size:0]     LVL_FULL   = (FIFO_addr_size+1)'(DEPTH);
  localparam logic [FIFO_addr_size:0]     LVL_ONE    = (FIFO_addr_size+1)'(1);
  localparam logic [FIFO_addr_size-1:0]   PTR_ONE    = FIFO_addr_size'(1);
  localparam logic [7:0]                  BURST_LAST = 8'(BURST_LEN - 1);
  localparam logic [7:0]                  BURST_ONE  = 8'd1;

  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

  state_t                    state_q, state_d;
  logic                      last_owner_q, last_owner_d;
  logic [7:0]                burst_cnt_q, burst_cnt_d;
  logic [FIFO_addr_size-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_addr_size-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_addr_size:0]   level_q, level_d;
  logic                      rd_valid_q, rd_valid_d;

  assign full  = (level_q == LVL_FULL);
  assign empty = (level_q == '0);

  always_comb begin
    state_d      = state_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    ack0         = 1'b0;
    ack1         = 1'b0;
    grant        = '0;
    w_data       = data0;
    unique case (state_q)
      IDLE: begin
        if (req0 && req1)
          state_d = last_owner_q ? GNT0 : GNT1;
        else if (req0)
          state_d = GNT0;
        else if (req1)
          state_d = GNT1;
      end
      GNT0: begin
        grant  = 2'b01;
        w_data = data0;
        ack0   = req0 & ~full;
        // A full stall neither advances the burst nor releases the grant.
        if (!req0 || (ack0 && burst_cnt_q == BURST_LAST)) begin
          state_d      = req1 ? GNT1 : (req0 ? GNT0 : IDLE);
          last_owner_d = 1'b0;
          burst_cnt_d  = '0;
        end else if (ack0) begin
          burst_cnt_d = burst_cnt_q + BURST_ONE;
        end
      end
      GNT1: begin
        grant  = 2'b10;
        w_data = data1;
        ack1   = req1 & ~full;
        if (!req1 || (ack1 && burst_cnt_q == BURST_LAST)) begin
          state_d      = req0 ? GNT0 : (req1 ? GNT1 : IDLE);
          last_owner_d = 1'b1;
          burst_cnt_d  = '0;
        end else if (ack1) begin
          burst_cnt_d = burst_cnt_q + BURST_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Nothing is handshaked while reset is asserted.
    if (rst) begin
      ack0  = 1'b0;
      ack1  = 1'b0;
      grant = '0;
    end
  end

  assign rd_ack   = rd_req & ~empty & ~rst;
  assign w_en     = ack0 | ack1;
  assign r_en     = rd_ack;
  assign w_addr   = wr_ptr_q;
  assign r_addr   = rd_ptr_q;
  assign level    = level_q;
  assign rd_valid = rd_valid_q;

  always_comb begin
    wr_ptr_d   = w_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d   = r_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    rd_valid_d = rd_ack;
    level_d    = level_q;
    unique case ({w_en, r_en})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_owner_q <= 1'b1;
      burst_cnt_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      rd_valid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      rd_valid_q   <= rd_valid_d;
    end
  end

`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0] stall0_cnt_q, stall0_cnt_d;
  logic [15:0] stall1_cnt_q, stall1_cnt_d;

  always_comb begin
    stall0_cnt_d = stall0_cnt_q;
    stall1_cnt_d = stall1_cnt_q;
    if (state_q == GNT0 && req0 && full && stall0_cnt_q != '1)
      stall0_cnt_d = stall0_cnt_q + 16'd1;
    if (state_q == GNT1 && req1 && full && stall1_cnt_q != '1)
      stall1_cnt_d = stall1_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall0_cnt_q <= '0;
      stall1_cnt_q <= '0;
    end else begin
      stall0_cnt_q <= stall0_cnt_d;
      stall1_cnt_q <= stall1_cnt_d;
    end
  end

  assign stall0_cnt = stall0_cnt_q;
  assign stall1_cnt = stall1_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Self-checking bench for fifo_wr_arb: per-cycle behavioural model plus directed literal checks.
module tb_fifo_wr_arb;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int BL = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst, req0, req1, rd_req;
  logic [DW-1:0] data0, data1;
  logic          ack0, ack1, rd_ack, rd_valid, w_en, r_en, full, empty;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic [AW:0]   level;
  logic [1:0]    grant;
`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0]   stall0_cnt, stall1_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  fifo_wr_arb #(.FIFO_data_size(DW), .FIFO_addr_size(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .data0(data0), .ack0(ack0),
    .req1(req1), .data1(data1), .ack1(ack1),
    .rd_req(rd_req), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .w_en(w_en), .w_addr(w_addr), .w_data(w_data),
    .r_en(r_en), .r_addr(r_addr),
    .full(full), .empty(empty), .level(level), .grant(grant)
`ifdef FIFO_WR_ARB_STAT_EN
    , .stall0_cnt(stall0_cnt), .stall1_cnt(stall1_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: owner 0=none 1=producer0 2=producer1; counts are plain integers.
  int m_owner, m_used, m_last, m_level, m_wr, m_rd, m_rdv, m_s0, m_s1;
  bit m_ok = 0;

  always @(negedge clk) begin
    bit e_full, e_empty, e_a0, e_a1, e_rd;
    int e_grant;
    e_full  = (m_level == DEPTH);
    e_empty = (m_level == 0);
    if (rst) begin
      e_a0 = 0; e_a1 = 0; e_rd = 0; e_grant = 0;
    end else begin
      e_grant = (m_owner == 1) ? 1 : (m_owner == 2) ? 2 : 0;
      e_a0 = (m_owner == 1) && req0 && !e_full;
      e_a1 = (m_owner == 2) && req1 && !e_full;
      e_rd = rd_req && !e_empty;
    end
    if (m_ok) begin
      chk("ack0", ack0, e_a0);
      chk("ack1", ack1, e_a1);
      chk("w_en", w_en, e_a0 | e_a1);
      chk("w_addr", w_addr, m_wr % DEPTH);
      if (e_a0 | e_a1) chk("w_data", w_data, e_a0 ? data0 : data1);
      chk("rd_ack", rd_ack, e_rd);
      chk("r_en", r_en, e_rd);
      chk("r_addr", r_addr, m_rd % DEPTH);
      chk("rd_valid", rd_valid, m_rdv);
      chk("level", level, m_level);
      chk("full", full, e_full);
      chk("empty", empty, e_empty);
      chk("grant", grant, e_grant);
`ifdef FIFO_WR_ARB_STAT_EN
      chk("stall0_cnt", stall0_cnt, m_s0);
      chk("stall1_cnt", stall1_cnt, m_s1);
`endif
    end
    if (rst) begin
      m_ok = 1; m_owner = 0; m_used = 0; m_last = 1;
      m_level = 0; m_wr = 0; m_rd = 0; m_rdv = 0; m_s0 = 0; m_s1 = 0;
    end else if (m_ok) begin
      m_wr    += int'(e_a0 | e_a1);
      m_rd    += int'(e_rd);
      m_level += int'(e_a0 | e_a1) - int'(e_rd);
      m_rdv    = int'(e_rd);
      if (m_owner == 1 && req0 && e_full && m_s0 < 65535) m_s0++;
      if (m_owner == 2 && req1 && e_full && m_s1 < 65535) m_s1++;
      if (m_owner == 0) begin
        if (req0 && req1) m_owner = (m_last == 1) ? 1 : 2;
        else if (req0)    m_owner = 1;
        else if (req1)    m_owner = 2;
      end else begin
        bit mine, other, took;
        mine  = (m_owner == 1) ? req0 : req1;
        other = (m_owner == 1) ? req1 : req0;
        took  = e_a0 | e_a1;
        if (!mine || (took && m_used == BL - 1)) begin
          m_last  = m_owner - 1;
          m_used  = 0;
          m_owner = other ? (3 - m_owner) : (mine ? m_owner : 0);
        end else if (took) begin
          m_used++;
        end
      end
    end
  end

  int own_log[0:31];
  int addr_log[0:31];

  task automatic collect(input int n, input bit drop0, input bit drop1, output int cyc);
    int got = 0;
    bit a0, a1;
    cyc = 0;
    while (got < n && cyc < 64) begin
      @(negedge clk);
      cyc++;
      a0 = ack0; a1 = ack1;
      if (a0 | a1) begin
        own_log[got]  = int'(a1);
        addr_log[got] = int'(w_addr);
        got++;
      end
      @(posedge clk); #1;
      if (a0) data0 = data0 + 16'd1;
      if (a1) data1 = data1 + 16'd1;
      if (got == n) begin
        if (drop0) req0 = 0;
        if (drop1) req1 = 0;
      end
    end
    chk("collect_count", got, n);
  endtask

  task automatic drain_to(input int tgt);
    for (int unsigned i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      if (int'(level) > tgt) rd_req = 1;
      else begin
        rd_req = 0;
        break;
      end
    end
    rd_req = 0;
    chk("drain_level", level, tgt);
  endtask

  initial begin
    int cyc;
    int unsigned s1a;
    rst = 1; req0 = 0; req1 = 0; rd_req = 0; data0 = '0; data1 = '0;
    s1a = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("lit_rst_level", level, 0);
    chk("lit_rst_empty", empty, 1);
    chk("lit_rst_full", full, 0);
    chk("lit_rst_grant", grant, 0);
    chk("lit_rst_wen", w_en, 0);
    chk("lit_rst_ren", r_en, 0);
    chk("lit_rst_rdvalid", rd_valid, 0);

    // producer 0 alone: one idle cycle then six consecutive writes
    @(posedge clk); #1;
    req0 = 1; data0 = 16'hA000;
    collect(6, 1, 0, cyc);
    chk("lit_p0_cycles", cyc, 7);
    for (int unsigned k = 0; k < 6; k++) chk("lit_p0_addr", addr_log[k], k);
    @(negedge clk);
    chk("lit_p0_level", level, 6);
    drain_to(0);
    @(posedge clk); #1 rd_req = 1;
    @(negedge clk);
    chk("lit_rdack_empty", rd_ack, 0);
    @(posedge clk); #1 rd_req = 0;

    // both producers: alternating bursts of four, no gaps, fills to full
    rst = 1;
    @(posedge clk); #1 rst = 0;
    req0 = 1; req1 = 1; data0 = 16'hB000; data1 = 16'hC000;
    collect(16, 1, 0, cyc);
    chk("lit_arb_cycles", cyc, 17);
    for (int unsigned k = 0; k < 16; k++) chk("lit_arb_owner", own_log[k], (k / 4) % 2);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("lit_full_flag", full, 1);
    chk("lit_full_level", level, 16);
    chk("lit_full_grant", grant, 2'b10);
    chk("lit_full_ack1", ack1, 0);
`ifdef FIFO_WR_ARB_STAT_EN
    s1a = stall1_cnt;
    repeat (10) @(negedge clk);
    chk("lit_stall1_delta", stall1_cnt - s1a[15:0], 10);
`endif
    @(posedge clk); #1 rd_req = 1;
    @(negedge clk);
    chk("lit_full_ren", r_en, 1);
    chk("lit_full_raddr", r_addr, 0);
    @(posedge clk); #1 rd_req = 0;
    @(negedge clk);
    chk("lit_resume_level", level, 15);
    chk("lit_resume_ack1", ack1, 1);
    chk("lit_resume_waddr", w_addr, 0);
    @(posedge clk); #1 req1 = 0;

    // simultaneous write and read at level 5
    drain_to(5);
    req0 = 1; data0 = 16'hD000;
    @(posedge clk); #1 rd_req = 1;
    @(negedge clk);
    chk("lit_rw_wen", w_en, 1);
    chk("lit_rw_ren", r_en, 1);
    @(posedge clk); #1 req0 = 0; rd_req = 0;
    @(negedge clk);
    chk("lit_rw_level", level, 5);
    chk("lit_rw_rdvalid", rd_valid, 1);
    drain_to(0);

    // reset in the middle of a burst at level 3
    @(posedge clk); #1 req0 = 1; data0 = 16'hE000;
    collect(3, 0, 0, cyc);
    chk("lit_mid_level", level, 3);
    rst = 1;
    @(negedge clk);
    chk("lit_mid_ack0", ack0, 0);
    chk("lit_mid_wen", w_en, 0);
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    chk("lit_post_level", level, 0);
    chk("lit_post_waddr", w_addr, 0);
    chk("lit_post_raddr", r_addr, 0);
    chk("lit_post_grant", grant, 0);
`ifdef FIFO_WR_ARB_STAT_EN
    chk("lit_post_stall1", stall1_cnt, 0);
`endif
    @(posedge clk); #1 req0 = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
